// File: rtl/pipelined_reduce_gate_if.sv
// Handshake and result bundle for pipelined_reduce_gate.
// The master drives operands and out_ready; the slave (the gate) returns results.
interface pipelined_reduce_gate_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_result;
  logic             out_partial;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] result_count;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_partial, out_mode, result_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_partial, out_mode, result_count
  );
endinterface

// File: rtl/pipelined_reduce_gate.sv
// WIDTH-input AND/OR/XOR/NAND reduction tree plus lower-half tree, clog2(WIDTH) cycles, one result per cycle.
// A held output (out_valid & ~out_ready) freezes every stage and drops in_ready combinationally.
module pipelined_reduce_gate #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                    clk,
  input logic                    reset,
  pipelined_reduce_gate_if.slave bus
);

  localparam int STAGES = $clog2(WIDTH);
  localparam int LEAVES = 1 << STAGES;
  localparam int HALF   = WIDTH / 2;

  function automatic logic red_op(input logic [1:0] mode, input logic a, input logic b);
    case (mode)
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic int flog2(input int v);
    int r;
    r = 0;
    for (int b = 1; b < 31; b++) begin
      if ((v >> b) != 0) r = b;
    end
    return r;
  endfunction

  logic                   stall;
  logic                   ident;
  logic [LEAVES-1:0]      leaf_full;
  logic [LEAVES-1:0]      leaf_half;
  logic [2*LEAVES-1:1]    full_tree;
  logic [2*LEAVES-1:1]    half_tree;
  logic [LEAVES-1:1]      full_d, full_q;
  logic [LEAVES-1:1]      half_d, half_q;
  logic [1:0]             mode_d [1:STAGES];
  logic [1:0]             mode_q [1:STAGES];
  logic [STAGES:1]        vld_d, vld_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;

  assign stall = vld_q[STAGES] & ~bus.out_ready;
  assign ident = (bus.in_mode == 2'b00) || (bus.in_mode == 2'b11);

  // Padding leaves take the identity of the base operator so they never affect the result.
  always_comb begin
    leaf_full              = {LEAVES{ident}};
    leaf_half              = {LEAVES{ident}};
    leaf_full[WIDTH-1:0]   = bus.in_data;
    leaf_half[HALF-1:0]    = bus.in_data[HALF-1:0];
  end

  // Heap layout: node 1 is the root, node j has children 2j and 2j+1, leaves sit at LEAVES..2*LEAVES-1.
  assign full_tree = {leaf_full, full_q};
  assign half_tree = {leaf_half, half_q};

  always_comb begin
    mode_d[1] = bus.in_mode;
    vld_d[1]  = bus.in_valid;
    for (int s = 2; s <= STAGES; s++) begin
      mode_d[s] = mode_q[s-1];
      vld_d[s]  = vld_q[s-1];
    end
  end

  always_comb begin
    full_d = '0;
    half_d = '0;
    for (int i = 1; i < LEAVES; i++) begin
      full_d[i] = red_op(mode_d[STAGES - flog2(i)], full_tree[2*i], full_tree[2*i+1]);
      half_d[i] = red_op(mode_d[STAGES - flog2(i)], half_tree[2*i], half_tree[2*i+1]);
    end
    if (mode_d[STAGES] == 2'b11) begin
      full_d[1] = ~full_d[1];
      half_d[1] = ~half_d[1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q[STAGES] && bus.out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      full_q <= '0;
      half_q <= '0;
      cnt_q  <= '0;
      for (int s = 1; s <= STAGES; s++) mode_q[s] <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) begin
        vld_q  <= vld_d;
        full_q <= full_d;
        half_q <= half_d;
        for (int s = 1; s <= STAGES; s++) mode_q[s] <= mode_d[s];
      end
    end
  end

  assign bus.in_ready     = ~stall;
  assign bus.out_valid    = vld_q[STAGES];
  assign bus.out_result   = full_tree[1];
  assign bus.out_partial  = half_tree[1];
  assign bus.out_mode     = mode_q[STAGES];
  assign bus.result_count = cnt_q;

endmodule
